// File: rtl/multicast_buffer_ctrl.sv
// Multicast receive buffer: scan-loaded ID, tag match against the bus, PE-side FIFO.
// Optional MCAST_BROADCAST_EN: an all-ones tag matches every enabled controller.
module multicast_buffer_ctrl #(
  parameter int ID_BITS   = 8,
  parameter int DATA_SIZE = 16,
  parameter int DEPTH     = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ctrl_enable,
  input  logic                       id_scan_en,
  input  logic                       id_scan_i,
  output logic                       id_scan_o,
  input  logic                       flush,
  input  logic                       cast_valid_i,
  input  logic [ID_BITS-1:0]         cast_tag_i,
  input  logic [DATA_SIZE-1:0]       cast_data_i,
  output logic                       cast_ready_o,
  output logic                       pe_valid_o,
  output logic [DATA_SIZE-1:0]       pe_data_o,
  input  logic                       pe_ready_i,
  output logic [$clog2(DEPTH):0]     fifo_count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [ID_BITS-1:0]   id_q;
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [CW-1:0]        count;
  logic [DATA_SIZE-1:0] mem [DEPTH];

  logic tag_hit;
  logic match;
  logic push;
  logic pop;

`ifdef MCAST_BROADCAST_EN
  assign tag_hit = (cast_tag_i == id_q) || (&cast_tag_i);
`else
  assign tag_hit = (cast_tag_i == id_q);
`endif

  // Matching is suppressed while the ID is mid-scan, so a partial ID never captures words.
  assign match        = ctrl_enable && !id_scan_en && cast_valid_i && tag_hit;
  assign cast_ready_o = !match || (count < DEPTH_C);
  assign push         = match && (count < DEPTH_C) && !flush;
  assign pop          = pe_valid_o && pe_ready_i;

  assign pe_valid_o   = (count != '0);
  assign pe_data_o    = pe_valid_o ? mem[rd_ptr] : '0;
  assign fifo_count_o = count;
  assign id_scan_o    = id_q[ID_BITS-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      id_q <= '0;
    end else if (id_scan_en) begin
      id_q <= {id_q[ID_BITS-2:0], id_scan_i};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; entries are only visible through count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= cast_data_i;
  end

endmodule
